gcd_job_sequencer: RTL and testbench

//  Upstream feeder for the subtractive GCD unit (controlpath + datapath pair).

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_req_fifo.sv | 79 +++++++
 rtl/gcd_job_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD job sequencer and the controlpath/datapath
// benches of the subtractive GCD core.
//   GCD_WIDTH   : default operand/result width
//   gcd_state_e : 3-bit sequencer state encoding
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRST   = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_RUN    = 3'd4,
        ST_OUTPUT = 3'd5
    } gcd_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// -----------------------------------------------------------------------------
// gcd_req_fifo
// Synchronous request FIFO holding packed operand pairs. Head entry is read
// combinationally; a push into an empty FIFO becomes visible one cycle later.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (pointers/count)
//   push, push_data   : write request and data (ignored when full)
//   pop               : consume head entry (ignored when empty)
//   pop_data          : current head entry
//   full, empty       : status derived from registered count
//   count             : number of stored entries
// -----------------------------------------------------------------------------
module gcd_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // DEPTH is a power of two, so pointer increment wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// -----------------------------------------------------------------------------
// gcd_job_sequencer
// Feeds operand pairs from a valid/ready queue into the subtractive GCD core:
// restart pulse, start strobe with operand A, operand B, then waits for
// core_done and presents the result on a valid/ready output. Pairs with a
// zero operand bypass the core (gcd(x,0)=x, gcd(0,0)=0).
// Optional feature macro: GCD_TIMEOUT_EN -- RUN-state watchdog of MAX_CYCLES
// cycles; on expiry the job returns out_gcd=0, out_err=1.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b : operand pair input handshake
//   core_rst, core_start, core_data : command/operand interface to the core
//   core_done, core_result   : core completion level and result
//   out_valid/out_ready/out_gcd/out_err : result output handshake
//   busy                     : job in progress or queue non-empty
// -----------------------------------------------------------------------------
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH      = GCD_WIDTH,
    parameter int DEPTH      = 4,
    parameter int MAX_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_rst,
    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    gcd_state_e         state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               core_rst_q, core_rst_d;
    logic               core_start_q, core_start_d;
    logic [WIDTH-1:0]   core_data_q, core_data_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_gcd_q, out_gcd_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [2*WIDTH-1:0] fifo_head;
    logic [WIDTH-1:0]   head_a, head_b;

`ifdef GCD_TIMEOUT_EN
    localparam int             WD_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYCLES - 1);
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               out_err_q, out_err_d;
`endif

    gcd_req_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign head_a    = fifo_head[2*WIDTH-1:WIDTH];
    assign head_b    = fifo_head[WIDTH-1:0];
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        out_gcd_d = out_gcd_q;
        fifo_pop  = 1'b0;
`ifdef GCD_TIMEOUT_EN
        out_err_d = out_err_q;
        // Held at zero outside RUN, so every RUN entry starts counting from 0.
        wd_cnt_d  = (state_q == ST_RUN) ? wd_cnt_q + 1'b1 : '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_a_d   = head_a;
                    op_b_d   = head_b;
                    if (head_a == '0 || head_b == '0) begin
                        // A zero operand means the other one is the GCD.
                        out_gcd_d = head_a | head_b;
`ifdef GCD_TIMEOUT_EN
                        out_err_d = 1'b0;
`endif
                        state_d   = ST_OUTPUT;
                    end else begin
                        state_d = ST_CRST;
                    end
                end
            end
            ST_CRST:   state_d = ST_LOAD_A;
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_RUN;
            ST_RUN: begin
                if (core_done) begin
                    out_gcd_d = core_result;
`ifdef GCD_TIMEOUT_EN
                    out_err_d = 1'b0;
`endif
                    state_d   = ST_OUTPUT;
                end
`ifdef GCD_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    out_gcd_d = '0;
                    out_err_d = 1'b1;
                    state_d   = ST_OUTPUT;
                end
`endif
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Core-facing and handshake outputs are registered from the next state.
        core_rst_d   = (state_d == ST_CRST);
        core_start_d = (state_d == ST_LOAD_A);
        out_valid_d  = (state_d == ST_OUTPUT);
        case (state_d)
            ST_LOAD_A:        core_data_d = op_a_q;
            ST_LOAD_B, ST_RUN: core_data_d = op_b_q;
            default:          core_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_gcd_q    <= '0;
`ifdef GCD_TIMEOUT_EN
            out_err_q    <= 1'b0;
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            core_rst_q   <= core_rst_d;
            core_start_q <= core_start_d;
            core_data_q  <= core_data_d;
            out_valid_q  <= out_valid_d;
            out_gcd_q    <= out_gcd_d;
`ifdef GCD_TIMEOUT_EN
            out_err_q    <= out_err_d;
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    // Operand holding registers carry no control meaning and need no reset.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign core_rst   = core_rst_q;
    assign core_start = core_start_q;
    assign core_data  = core_data_q;
    assign out_valid  = out_valid_q;
    assign out_gcd    = out_gcd_q;
`ifdef GCD_TIMEOUT_EN
    assign out_err    = out_err_q;
`else
    assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
module tb_gcd_job_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         core_rst;
    logic         core_start;
    logic [W-1:0] core_data;
    logic         core_done = 1'b0;
    logic [W-1:0] core_result = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gcd_job_sequencer #(
        .WIDTH      (W),
        .DEPTH      (4),
        .MAX_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_rst    (core_rst),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_err     (out_err),
        .busy        (busy)
    );

    // Reference GCD by Euclid's remainder method (independent of subtraction).
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural GCD core: restart, start+A, B, random latency, done level.
    int           m_phase = 0;
    int           m_lat = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    bit           m_stuck = 1'b0;
    int           rst_pulses = 0;
    int           cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_rst) begin
            rst_pulses <= rst_pulses + 1;
            core_done  <= 1'b0;
            m_phase    <= 0;
        end else if (core_start) begin
            m_a       <= core_data;
            core_done <= 1'b0;
            m_phase   <= 1;
        end else if (m_phase == 1) begin
            m_b     <= core_data;
            m_lat   <= $urandom_range(6, 1);
            m_phase <= 2;
        end else if (m_phase == 2 && !m_stuck) begin
            if (m_lat <= 1) begin
                core_done   <= 1'b1;
                core_result <= ref_gcd(m_a, m_b);
                m_phase     <= 3;
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output bit ok);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        if (!ok) begin
            total_cnt++;
            $display("FAIL out_valid_timeout: out_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic get_result(input int delay, output logic [W-1:0] g, output logic e, output bit ok);
        g = '0;
        e = 1'b0;
        @(negedge clk);
        wait_out_valid(ok);
        if (ok) begin
            repeat (delay) @(negedge clk);
            g = out_gcd;
            e = out_err;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else pass_cnt++;
        total_cnt++; if (core_rst !== 1'b0) $display("FAIL reset_core_rst: got %b, required 0", core_rst); else pass_cnt++;
        total_cnt++; if (core_start !== 1'b0) $display("FAIL reset_core_start: got %b, required 0", core_start); else pass_cnt++;
        total_cnt++; if (core_data !== 16'd0) $display("FAIL reset_core_data: got %0h, required 0", core_data); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_gcd !== 16'd0) $display("FAIL reset_out_gcd: got %0h, required 0", out_gcd); else pass_cnt++;
        total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b, required 0", out_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [W-1:0] g;
        logic         e;
        bit           ok;
        int           n = 0;
        push_pair(16'd48, 16'd18);
        while (!core_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++; if (core_rst !== 1'b1) $display("FAIL basic_core_rst: got %b, required 1", core_rst); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (core_start !== 1'b1 || core_data !== 16'd48 || core_rst !== 1'b0)
            $display("FAIL basic_load_a: start=%b data=%0d rst=%b, required 1/48/0", core_start, core_data, core_rst);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (core_start !== 1'b0 || core_data !== 16'd18)
            $display("FAIL basic_load_b: start=%b data=%0d, required 0/18", core_start, core_data);
        else pass_cnt++;
        get_result(0, g, e, ok);
        if (ok) begin
            total_cnt++; if (g !== 16'd6) $display("FAIL basic_gcd: got %0d, required 6", g); else pass_cnt++;
            total_cnt++; if (e !== 1'b0) $display("FAIL basic_err: got %b, required 0", e); else pass_cnt++;
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] g;
        logic         e;
        bit           ok;
        int           p0;
        p0 = rst_pulses;
        push_pair(16'd0, 16'd35);
        push_pair(16'd0, 16'd0);
        get_result(0, g, e, ok);
        if (ok) begin
            total_cnt++; if (g !== 16'd35) $display("FAIL bypass_0_35: got %0d, required 35", g); else pass_cnt++;
            total_cnt++; if (e !== 1'b0) $display("FAIL bypass_err: got %b, required 0", e); else pass_cnt++;
        end
        get_result(1, g, e, ok);
        if (ok) begin
            total_cnt++; if (g !== 16'd0) $display("FAIL bypass_0_0: got %0d, required 0", g); else pass_cnt++;
        end
        repeat (3) @(negedge clk);
        total_cnt++; if (rst_pulses !== p0) $display("FAIL bypass_no_core_rst: pulses %0d, required %0d", rst_pulses, p0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [5];
        logic [W-1:0] pb [5];
        logic [W-1:0] g;
        logic         e;
        bit           ok;
        int           i = 0;
        int           n = 0;
        pa[0] = 16'd12; pb[0] = 16'd8;
        pa[1] = 16'd7;  pb[1] = 16'd13;
        pa[2] = 16'd9;  pb[2] = 16'd9;
        pa[3] = 16'($urandom_range(200, 1)); pb[3] = 16'($urandom_range(200, 1));
        pa[4] = 16'($urandom_range(200, 1)); pb[4] = 16'($urandom_range(200, 1));
        out_ready = 1'b0;
        while (i < 5 && n < 50) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            if (in_ready) i++;
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        // First pair is popped into the FSM, the next four fill the queue.
        total_cnt++; if (i !== 5) $display("FAIL b2b_accepted: got %0d, required 5", i); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_full: in_ready=%b, required 0", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b, required 1", busy); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            get_result($urandom_range(3, 0), g, e, ok);
            if (ok) begin
                total_cnt++;
                if (g !== ref_gcd(pa[k], pb[k]) || e !== 1'b0)
                    $display("FAIL b2b_result%0d: gcd(%0d,%0d) got %0d err %b, required %0d err 0",
                             k, pa[k], pb[k], g, e, ref_gcd(pa[k], pb[k]));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] g;
        logic         e;
        bit           ok;
        bit           stable = 1'b1;
        int           p0;
        push_pair(16'd100, 16'd75);
        push_pair(16'd14, 16'd21);
        wait_out_valid(ok);
        if (ok) begin
            p0 = rst_pulses;
            repeat (10) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_gcd !== 16'd25) stable = 1'b0;
            end
            total_cnt++; if (!stable) $display("FAIL stall_stable: out_valid=%b out_gcd=%0d, required 1/25", out_valid, out_gcd); else pass_cnt++;
            total_cnt++; if (rst_pulses !== p0) $display("FAIL stall_core_rst: pulses %0d, required %0d", rst_pulses, p0); else pass_cnt++;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_drop: out_valid=%b, required 0", out_valid); else pass_cnt++;
        end
        get_result(0, g, e, ok);
        if (ok) begin
            total_cnt++; if (g !== 16'd7) $display("FAIL stall_next: got %0d, required 7", g); else pass_cnt++;
        end
    endtask

    task automatic test_midjob_reset();
        logic [W-1:0] g;
        logic         e;
        bit           ok;
        int           n = 0;
        push_pair(16'd30, 16'd12);
        while (!core_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b, required 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b, required 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b, required 1", in_ready); else pass_cnt++;
        push_pair(16'd21, 16'd14);
        get_result(0, g, e, ok);
        if (ok) begin
            total_cnt++; if (g !== 16'd7 || e !== 1'b0) $display("FAIL midrst_next: got %0d err %b, required 7 err 0", g, e); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q [$];
        int           jobs = 24;
        fork
            begin
                for (int j = 0; j < jobs; j++) begin
                    logic [W-1:0] a, b;
                    a = ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom_range(255, 1));
                    b = ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom_range(255, 1));
                    exp_q.push_back(ref_gcd(a, b));
                    push_pair(a, b);
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < jobs; j++) begin
                    logic [W-1:0] g, x;
                    logic         e;
                    bit           ok;
                    get_result($urandom_range(4, 0), g, e, ok);
                    if (ok) begin
                        x = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                        total_cnt++; if (g !== x) $display("FAIL random_gcd%0d: got %0d, required %0d", j, g, x); else pass_cnt++;
                        total_cnt++; if (e !== 1'b0) $display("FAIL random_err%0d: got %b, required 0", j, e); else pass_cnt++;
                    end
                end
            end
        join
    endtask

`ifdef GCD_TIMEOUT_EN
    task automatic test_timeout();
        logic [W-1:0] g;
        logic         e;
        bit           ok;
        int           n = 0;
        int           t0;
        m_stuck = 1'b1;
        push_pair(16'd5, 16'd10);
        while (!core_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        wait_out_valid(ok);
        if (ok) begin
            // LOAD_A, LOAD_B, 16 RUN cycles, then OUTPUT.
            total_cnt++; if (cyc - t0 !== 18) $display("FAIL timeout_latency: got %0d, required 18", cyc - t0); else pass_cnt++;
            total_cnt++; if (out_err !== 1'b1) $display("FAIL timeout_err: got %b, required 1", out_err); else pass_cnt++;
            total_cnt++; if (out_gcd !== 16'd0) $display("FAIL timeout_gcd: got %0d, required 0", out_gcd); else pass_cnt++;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        m_stuck = 1'b0;
        push_pair(16'd21, 16'd14);
        get_result(0, g, e, ok);
        if (ok) begin
            total_cnt++; if (g !== 16'd7) $display("FAIL timeout_recover_gcd: got %0d, required 7", g); else pass_cnt++;
            total_cnt++; if (e !== 1'b0) $display("FAIL timeout_recover_err: got %b, required 0", e); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_midjob_reset();
        test_random();
`ifdef GCD_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
